// File: rtl/load_store_unit.sv
// RISC-V load/store unit: aligns core accesses onto a word-wide memory port
// and returns sign/zero-extended load results to the register file.
module load_store_unit #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [4:0]  req_rd,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        wb_en,
    output logic [4:0]  wb_addr,
    output logic [31:0] wb_data,
    output logic        err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_WB
    } state_t;

    localparam logic [15:0] LP_TIMEOUT = 16'(TIMEOUT);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [2:0]  r_funct3;
    logic        r_we;
    logic [4:0]  r_rd;
    logic [15:0] r_cnt;
    logic        r_err;
    logic [4:0]  r_wb_addr;
    logic [31:0] r_wb_data;

    logic        w_legal;
    logic        w_accept;
    logic        w_abort;
    logic        w_busy;
    logic        w_timeout;
    logic [31:0] w_byte_sh;
    logic [31:0] w_half_sh;
    logic [31:0] w_load;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;

    always_comb begin
        w_legal = 1'b0;
        case (req_funct3)
            3'b000:  w_legal = 1'b1;
            3'b001:  w_legal = !req_addr[0];
            3'b010:  w_legal = (req_addr[1:0] == 2'b00);
            3'b100:  w_legal = !req_we;
            3'b101:  w_legal = !req_we && !req_addr[0];
            default: w_legal = 1'b0;
        endcase
    end

    assign w_busy    = (r_state == S_REQ) || (r_state == S_WAIT);
    // Abort once this cycle would be the TIMEOUT-th spent in REQ/WAIT
    assign w_timeout = w_busy && ((r_cnt + 16'd1) == LP_TIMEOUT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_abort     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    w_accept = 1'b1;
                    if (w_legal) begin
                        w_state_nxt = S_REQ;
                    end else begin
                        w_abort = 1'b1;
                    end
                end
            end
            S_REQ: begin
                if (mem_gnt) begin
                    w_state_nxt = r_we ? S_IDLE : S_WAIT;
                end else if (w_timeout) begin
                    w_state_nxt = S_IDLE;
                    w_abort     = 1'b1;
                end
            end
            S_WAIT: begin
                if (mem_rvalid) begin
                    w_state_nxt = S_WB;
                end else if (w_timeout) begin
                    w_state_nxt = S_IDLE;
                    w_abort     = 1'b1;
                end
            end
            S_WB: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign w_byte_sh = mem_rdata >> {r_addr[1:0], 3'b000};
    assign w_half_sh = mem_rdata >> {r_addr[1], 4'b0000};

    always_comb begin
        w_load = mem_rdata;
        case (r_funct3)
            3'b000:  w_load = {{24{w_byte_sh[7]}}, w_byte_sh[7:0]};
            3'b001:  w_load = {{16{w_half_sh[15]}}, w_half_sh[15:0]};
            3'b100:  w_load = {24'd0, w_byte_sh[7:0]};
            3'b101:  w_load = {16'd0, w_half_sh[15:0]};
            default: w_load = mem_rdata;
        endcase
    end

    always_comb begin
        w_be    = 4'b1111;
        w_wdata = r_wdata;
        case (r_funct3[1:0])
            2'b00: begin
                w_be    = 4'b0001 << r_addr[1:0];
                w_wdata = {4{r_wdata[7:0]}};
            end
            2'b01: begin
                w_be    = 4'b0011 << r_addr[1:0];
                w_wdata = {2{r_wdata[15:0]}};
            end
            default: begin
                w_be    = 4'b1111;
                w_wdata = r_wdata;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr    <= 32'd0;
            r_wdata   <= 32'd0;
            r_funct3  <= 3'd0;
            r_we      <= 1'b0;
            r_rd      <= 5'd0;
            r_cnt     <= 16'd0;
            r_err     <= 1'b0;
            r_wb_addr <= 5'd0;
            r_wb_data <= 32'd0;
        end else begin
            r_err <= w_abort;
            if (w_accept) begin
                r_addr   <= req_addr;
                r_wdata  <= req_wdata;
                r_funct3 <= req_funct3;
                r_we     <= req_we;
                r_rd     <= req_rd;
                r_cnt    <= 16'd0;
            end else if (w_busy) begin
                r_cnt <= r_cnt + 16'd1;
            end
            // x0 loads leave the visible writeback bundle untouched
            if ((r_state == S_WAIT) && mem_rvalid && (r_rd != 5'd0)) begin
                r_wb_addr <= r_rd;
                r_wb_data <= w_load;
            end
        end
    end

    assign req_ready = (r_state == S_IDLE) && !rst;
    assign mem_req   = (r_state == S_REQ);
    assign mem_we    = mem_req && r_we;
    assign mem_addr  = {r_addr[31:2], 2'b00};
    assign mem_be    = mem_req ? w_be : 4'b0000;
    assign mem_wdata = w_wdata;
    assign wb_en     = (r_state == S_WB) && (r_rd != 5'd0);
    assign wb_addr   = r_wb_addr;
    assign wb_data   = r_wb_data;
    assign err       = r_err;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit: aligned loads/stores,
// illegal accesses, timeout abort and mid-transaction reset.
module tb_load_store_unit;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [4:0]  req_rd;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    logic        req_ready;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        err;

    logic        to_req_ready;
    logic        to_mem_req;
    logic        to_mem_we;
    logic [31:0] to_mem_addr;
    logic [3:0]  to_mem_be;
    logic [31:0] to_mem_wdata;
    logic        to_wb_en;
    logic [4:0]  to_wb_addr;
    logic [31:0] to_wb_data;
    logic        to_err;

    int n_chk;
    int n_fail;
    int wb_cnt;
    int err_cnt;
    int to_wb_cnt;
    logic [4:0]  last_addr;
    logic [31:0] last_data;

    load_store_unit #(.TIMEOUT(16)) u_dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_funct3(req_funct3),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_be(mem_be), .mem_wdata(mem_wdata),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .err(err)
    );

    load_store_unit #(.TIMEOUT(4)) u_to (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(to_req_ready),
        .req_we(req_we), .req_funct3(req_funct3),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
        .mem_req(to_mem_req), .mem_we(to_mem_we), .mem_addr(to_mem_addr),
        .mem_be(to_mem_be), .mem_wdata(to_mem_wdata),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .wb_en(to_wb_en), .wb_addr(to_wb_addr), .wb_data(to_wb_data),
        .err(to_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wb_en) wb_cnt++;
        if (err) err_cnt++;
        if (to_wb_en) to_wb_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic [4:0] rd);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        req_rd     = rd;
        chk("issue_ready", 32'(req_ready), 32'd1);
        step();
        req_valid = 1'b0;
    endtask

    task automatic do_load(input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] rdata, input logic [4:0] rd,
                           input logic [3:0] be, input logic [31:0] exp);
        logic [31:0] waddr;
        waddr = {addr[31:2], 2'b00};
        issue(1'b0, f3, addr, 32'h0, rd);
        chk("ld_req", 32'(mem_req), 32'd1);
        chk("ld_addr", mem_addr, waddr);
        chk("ld_be", 32'(mem_be), 32'(be));
        chk("ld_we", 32'(mem_we), 32'd0);
        chk("ld_busy", 32'(req_ready), 32'd0);
        mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0;
        chk("ld_req_drop", 32'(mem_req), 32'd0);
        mem_rvalid = 1'b1;
        mem_rdata  = rdata;
        step();
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
        if (rd != 5'd0) begin
            last_addr = rd;
            last_data = exp;
        end
        chk("ld_wb_en", 32'(wb_en), 32'(rd != 5'd0));
        chk("ld_wb_addr", 32'(wb_addr), 32'(last_addr));
        chk("ld_wb_data", wb_data, last_data);
        step();
        chk("ld_wb_off", 32'(wb_en), 32'd0);
        chk("ld_ready", 32'(req_ready), 32'd1);
        chk("ld_hold", wb_data, last_data);
    endtask

    task automatic do_store(input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] wd, input logic [3:0] be,
                            input logic [31:0] exp_wd, input int dly);
        int wb0;
        wb0 = wb_cnt;
        issue(1'b1, f3, addr, wd, 5'd0);
        for (int i = 0; i <= dly; i++) begin
            chk("st_req", 32'(mem_req), 32'd1);
            chk("st_we", 32'(mem_we), 32'd1);
            chk("st_addr", mem_addr, {addr[31:2], 2'b00});
            chk("st_be", 32'(mem_be), 32'(be));
            chk("st_wdata", mem_wdata, exp_wd);
            if (i == dly) mem_gnt = 1'b1;
            step();
        end
        mem_gnt = 1'b0;
        chk("st_req_drop", 32'(mem_req), 32'd0);
        chk("st_ready", 32'(req_ready), 32'd1);
        chk("st_no_wb", 32'(wb_cnt - wb0), 32'd0);
    endtask

    task automatic do_illegal(input logic we, input logic [2:0] f3,
                              input logic [31:0] addr);
        int wb0;
        wb0 = wb_cnt;
        issue(we, f3, addr, 32'hFFFF_FFFF, 5'd6);
        chk("ill_err", 32'(err), 32'd1);
        chk("ill_no_req", 32'(mem_req), 32'd0);
        chk("ill_ready", 32'(req_ready), 32'd1);
        step();
        chk("ill_err_off", 32'(err), 32'd0);
        chk("ill_no_req2", 32'(mem_req), 32'd0);
        chk("ill_no_wb", 32'(wb_cnt - wb0), 32'd0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ready"}, 32'(req_ready), 32'd0);
        chk({tag, "_req"}, 32'(mem_req), 32'd0);
        chk({tag, "_we"}, 32'(mem_we), 32'd0);
        chk({tag, "_be"}, 32'(mem_be), 32'd0);
        chk({tag, "_wb_en"}, 32'(wb_en), 32'd0);
        chk({tag, "_err"}, 32'(err), 32'd0);
        chk({tag, "_maddr"}, mem_addr, 32'd0);
        chk({tag, "_mwdata"}, mem_wdata, 32'd0);
        chk({tag, "_wb_addr"}, 32'(wb_addr), 32'd0);
        chk({tag, "_wb_data"}, wb_data, 32'd0);
    endtask

    initial begin
        int wb0;
        int err0;
        n_chk      = 0;
        n_fail     = 0;
        wb_cnt     = 0;
        err_cnt    = 0;
        to_wb_cnt  = 0;
        last_addr  = 5'd0;
        last_data  = 32'd0;
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'd0;
        req_addr   = 32'd0;
        req_wdata  = 32'd0;
        req_rd     = 5'd0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'd0;

        step();
        step();
        chk_reset_outputs("rst");
        rst = 1'b0;
        step();
        chk("post_rst_ready", 32'(req_ready), 32'd1);

        do_load(3'b000, 32'h0000_1003, 32'h80FF_FF11, 5'd5, 4'b1000, 32'hFFFF_FF80);
        do_load(3'b101, 32'h0000_4002, 32'h8001_0000, 5'd9, 4'b1100, 32'h0000_8001);
        do_load(3'b001, 32'h0000_0010, 32'h0000_F00F, 5'd1, 4'b0011, 32'hFFFF_F00F);
        do_load(3'b100, 32'h0000_0021, 32'h1234_A5C3, 5'd2, 4'b0010, 32'h0000_00A5);
        do_load(3'b010, 32'h0000_0030, 32'hCAFE_BABE, 5'd31, 4'b1111, 32'hCAFE_BABE);
        do_load(3'b000, 32'h0000_0042, 32'h007F_0000, 5'd3, 4'b0100, 32'h0000_007F);
        wb0 = wb_cnt;
        do_load(3'b010, 32'h0000_3000, 32'hDEAD_BEEF, 5'd0, 4'b1111, 32'hDEAD_BEEF);
        chk("rd0_no_wb", 32'(wb_cnt - wb0), 32'd0);

        do_store(3'b001, 32'h0000_2002, 32'h1234_ABCD, 4'b1100, 32'hABCD_ABCD, 3);
        do_store(3'b000, 32'h0000_2003, 32'h0000_005A, 4'b1000, 32'h5A5A_5A5A, 0);
        do_store(3'b010, 32'h0000_2004, 32'h0BAD_F00D, 4'b1111, 32'h0BAD_F00D, 1);

        do_illegal(1'b0, 3'b010, 32'h0000_4001);
        do_illegal(1'b0, 3'b001, 32'h0000_4003);
        do_illegal(1'b1, 3'b100, 32'h0000_4000);
        do_illegal(1'b1, 3'b101, 32'h0000_4000);
        do_illegal(1'b1, 3'b010, 32'h0000_4002);
        do_illegal(1'b0, 3'b011, 32'h0000_4000);

        // Timeout on the TIMEOUT=4 instance: granted load, no rvalid
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        to_wb_cnt = 0;
        chk("to_idle_ready", 32'(to_req_ready), 32'd1);
        issue(1'b0, 3'b010, 32'h0000_5000, 32'h0, 5'd3);
        chk("to_req", 32'(to_mem_req), 32'd1);
        chk("to_err_t1", 32'(to_err), 32'd0);
        mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0;
        chk("to_wait_noreq", 32'(to_mem_req), 32'd0);
        chk("to_err_t2", 32'(to_err), 32'd0);
        step();
        chk("to_err_t3", 32'(to_err), 32'd0);
        step();
        chk("to_err_t4", 32'(to_err), 32'd0);
        chk("to_busy_t4", 32'(to_req_ready), 32'd0);
        step();
        chk("to_err_t5", 32'(to_err), 32'd1);
        chk("to_ready_t5", 32'(to_req_ready), 32'd1);
        chk("to_noreq_t5", 32'(to_mem_req), 32'd0);
        step();
        chk("to_err_t6", 32'(to_err), 32'd0);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h5555_AAAA;
        step();
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
        step();
        step();
        chk("to_late_rvalid", 32'(to_wb_cnt), 32'd0);
        chk("to_ready_end", 32'(to_req_ready), 32'd1);
        for (int i = 0; i < 4; i++) step();
        chk("main_idle", 32'(req_ready), 32'd1);

        // Reset while the main instance waits for read data
        issue(1'b0, 3'b010, 32'h0000_6000, 32'h0, 5'd4);
        mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0;
        chk("rw_in_wait", 32'(mem_req), 32'd0);
        wb0  = wb_cnt;
        err0 = err_cnt;
        rst  = 1'b1;
        #1;
        chk_reset_outputs("rw");
        step();
        chk_reset_outputs("rw2");
        rst        = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h1111_1111;
        step();
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
        step();
        step();
        chk("rw_no_wb", 32'(wb_cnt - wb0), 32'd0);
        chk("rw_no_err", 32'(err_cnt - err0), 32'd0);
        chk("rw_ready", 32'(req_ready), 32'd1);
        last_addr = 5'd0;
        last_data = 32'd0;
        do_load(3'b100, 32'h0000_7003, 32'hC3A5_0000, 5'd8, 4'b1000, 32'h0000_00C3);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

endmodule
